fpu_mul_seq: RTL and testbench
==============================

FPU_MUL_SEQ -- requirements
Module: fpu_mul_seq

Interface
REQ-001 SHALL have parameter: PRECISION, 32, operand/result width; legal values 32 (EW=8, M=24) or 64 (EW=11, M=53), where M includes the hidden bit.
REQ-002 SHALL have port: Clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: A  input  PRECISION  IEEE-754 multiplicand.
REQ-005 SHALL have port: B  input  PRECISION  IEEE-754 multiplier.
REQ-006 SHALL have port: InValid  input  1  A/B valid.
REQ-007 SHALL have port: InReady  output  1  block can accept an operation.
REQ-008 SHALL have port: Result  output  PRECISION  product, registered.
REQ-009 SHALL have port: OutValid  output  1  Result valid.
REQ-010 SHALL have port: OutReady  input  1  consumer accepts Result.

Function
REQ-011 SHALL use states IDLE, UNPACK, MULT, NORM, ROUND, DONE.
REQ-012 SHALL assert InReady only in IDLE; acceptance is InValid&InReady at a rising edge, capturing A and B; later changes on A/B are ignored.
REQ-013 SHALL go UNPACK -> DONE for special operands, else UNPACK -> MULT.
REQ-014 SHALL compute the M x M mantissa product radix-2 shift-add, one bit per cycle, in exactly M MULT cycles.
REQ-015 SHALL take NORM and ROUND one cycle each, then enter DONE.
REQ-016 SHALL raise OutValid M+4 edges after acceptance for normal operands (28 for PRECISION=32) and 2 edges after acceptance for special operands.
REQ-017 SHALL, in DONE, hold Result and OutValid stable until OutReady=1 at an edge, then return to IDLE; OutValid SHALL drop on that edge.
REQ-018 SHALL set sign = sign(A) XOR sign(B) for all non-NaN results.
REQ-019 SHALL compute exponent as Ea+Eb-bias in signed EW+2 bits; if product bit 2M-1 is set, shift right 1 and increment the exponent.
REQ-020 SHALL round to nearest, ties to even, using guard, round and sticky bits; a mantissa carry-out on rounding SHALL renormalise and increment the exponent.
REQ-021 SHALL return signed infinity if the final exponent is >= 2^EW-1 (overflow).
REQ-022 SHALL return signed zero if the final exponent is <= 0 (flush-to-zero underflow); no subnormal outputs.
REQ-023 SHALL treat subnormal inputs (exponent 0) as signed zero.
REQ-024 SHALL handle specials as follows: any NaN -> canonical NaN; 0 x inf -> canonical NaN; inf x nonzero -> signed inf; 0 x finite -> signed zero.
REQ-025 SHALL use canonical NaN = sign 0, exponent all ones, mantissa all ones (0x7FFFFFFF for PRECISION=32).

Reset
REQ-026 SHALL, with Reset=1 at an edge, enter IDLE from any state (aborting any operation) and clear OutValid and Result to 0 and all flags to 0; InReady SHALL be 0 while Reset=1.
REQ-027 SHALL assert InReady on the first edge after Reset deasserts.

Configuration
REQ-028 SHALL, with FPU_MUL_FLAGS_EN defined, add port Flags  output  4  {invalid, overflow, underflow, inexact}, registered with Result and valid with OutValid.
REQ-029 SHALL set invalid for NaN operands or 0 x inf, overflow per REQ-021, underflow per REQ-022, and inexact when discarded bits are nonzero or on overflow/underflow.
REQ-030 SHALL, without FPU_MUL_FLAGS_EN, omit the Flags port and its logic; Result timing is unchanged.

Verification
REQ-031 SHALL test: 0x3FC00000 x 0x3FC00000 (1.5 x 1.5) -> Result 0x40100000, OutValid 28 edges after acceptance.
REQ-032 SHALL test: 0x41200000 x 0x40000000 (10 x 2) -> 0x41A00000; then 0x7F000000 x 0x40000000 -> 0x7F800000, Flags overflow+inexact.
REQ-033 SHALL test: 0x00000000 x 0x7F800000 -> 0x7FFFFFFF, invalid set, OutValid 2 edges after acceptance.
REQ-034 SHALL test: 0xBF000000 x 0x00800000 -> 0x80000000, underflow set.
REQ-035 SHALL test: OutReady held low 10 cycles in DONE -> Result/OutValid stable, InReady 0; then OutReady=1 -> IDLE next edge.
REQ-036 SHALL test: Reset=1 mid-MULT -> OutValid 0, IDLE; next operation 1.5 x 1.5 -> 0x40100000.

Source files
------------

// File: rtl/fpu_mul_seq.sv
// fpu_mul_seq: sequential IEEE-754 multiplier (binary32 or binary64).
// Special operands resolve in UNPACK; normal operands go through an M-cycle
// radix-2 shift-add mantissa multiply, then one cycle each of normalise and
// round-to-nearest-even. Subnormal inputs are read as zero and results
// that would be subnormal are flushed to zero.
// Optional feature: define FPU_MUL_FLAGS_EN to add the 4-bit Flags output
// {invalid, overflow, underflow, inexact}.
module fpu_mul_seq #(
    parameter int unsigned PRECISION = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [PRECISION-1:0] A,
    input  logic [PRECISION-1:0] B,
    input  logic                 InValid,
    output logic                 InReady,
    output logic [PRECISION-1:0] Result,
    output logic                 OutValid,
    input  logic                 OutReady
`ifdef FPU_MUL_FLAGS_EN
    ,
    output logic [3:0]           Flags
`endif
);

    localparam int unsigned EW = (PRECISION == 64) ? 11 : 8;
    localparam int unsigned M  = (PRECISION == 64) ? 53 : 24;
    localparam int unsigned FW = M - 1;
    localparam int unsigned XW = EW + 2;
    localparam int unsigned PW = 2 * M;
    localparam int unsigned CW = $clog2(M);

    localparam logic [XW-1:0] BIAS    = XW'((1 << (EW - 1)) - 1);
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EW) - 1);
    localparam logic [PRECISION-1:0] QNAN = {1'b0, {(PRECISION-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE, UNPACK, MULT, NORM, ROUND, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PRECISION-1:0]   a_q, a_d, b_q, b_d;
    logic                   sign_q, sign_d;
    logic [XW-1:0]          exp_q, exp_d;
    logic [PW-1:0]          mcand_q, mcand_d;
    logic [M-1:0]           mplier_q, mplier_d;
    logic [PW-1:0]          prod_q, prod_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [M-1:0]           mant_q, mant_d;
    logic                   g_q, g_d, r_q, r_d, s_q, s_d;
    logic [PRECISION-1:0]   res_q, res_d;
    logic [PRECISION-1:0]   result_d;
    logic                   out_valid_d, in_ready_d;

    // Operand field decode and special-case classification
    logic [EW-1:0] ea_c, eb_c;
    logic [FW-1:0] fa_c, fb_c;
    logic          a_zero_c, b_zero_c, a_inf_c, b_inf_c, a_nan_c, b_nan_c;
    logic          nan_c, spec_c, spec_sign_c;
    logic [PRECISION-1:0] spec_res_c;

    // Rounding datapath
    logic          round_up_c;
    logic [M:0]    sum_c;
    logic [FW-1:0] frac_r_c;
    logic [XW-1:0] exp_r_c;
    logic          ovf_c, unf_c;
    logic [PRECISION-1:0] rnd_res_c;

    // Classify captured operands; build the result for special cases
    always_comb begin
        ea_c     = a_q[PRECISION-2 -: EW];
        eb_c     = b_q[PRECISION-2 -: EW];
        fa_c     = a_q[FW-1:0];
        fb_c     = b_q[FW-1:0];
        a_zero_c = (ea_c == '0);
        b_zero_c = (eb_c == '0);
        a_inf_c  = (&ea_c) && (fa_c == '0);
        b_inf_c  = (&eb_c) && (fb_c == '0);
        a_nan_c  = (&ea_c) && (fa_c != '0);
        b_nan_c  = (&eb_c) && (fb_c != '0);
        nan_c    = a_nan_c || b_nan_c || (a_zero_c && b_inf_c) || (a_inf_c && b_zero_c);
        spec_c   = a_zero_c || b_zero_c || a_inf_c || b_inf_c || a_nan_c || b_nan_c;
        spec_sign_c = a_q[PRECISION-1] ^ b_q[PRECISION-1];
        if (nan_c)
            spec_res_c = QNAN;
        else if (a_inf_c || b_inf_c)
            spec_res_c = {spec_sign_c, {EW{1'b1}}, {FW{1'b0}}};
        else
            spec_res_c = {spec_sign_c, {(PRECISION-1){1'b0}}};
    end

    // Round to nearest even, renormalise on carry-out, then range check
    always_comb begin
        round_up_c = g_q && (r_q || s_q || mant_q[0]);
        sum_c      = {1'b0, mant_q} + (M+1)'(round_up_c);
        if (sum_c[M]) begin
            frac_r_c = sum_c[FW:1];
            exp_r_c  = exp_q + XW'(1);
        end else begin
            frac_r_c = sum_c[FW-1:0];
            exp_r_c  = exp_q;
        end
        unf_c = exp_r_c[XW-1] || (exp_r_c == '0);
        ovf_c = !exp_r_c[XW-1] && (exp_r_c >= EXP_MAX);
        if (ovf_c)
            rnd_res_c = {sign_q, {EW{1'b1}}, {FW{1'b0}}};
        else if (unf_c)
            rnd_res_c = {sign_q, {(PRECISION-1){1'b0}}};
        else
            rnd_res_c = {sign_q, exp_r_c[EW-1:0], frac_r_c};
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        mant_d      = mant_q;
        g_d         = g_q;
        r_d         = r_q;
        s_d         = s_q;
        res_d       = res_q;
        result_d    = Result;
        out_valid_d = OutValid;

        case (state_q)
            IDLE: begin
                if (InValid && InReady) begin
                    a_d     = A;
                    b_d     = B;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d = spec_sign_c;
                if (spec_c) begin
                    res_d   = spec_res_c;
                    state_d = DONE;
                end else begin
                    exp_d    = XW'(ea_c) + XW'(eb_c) - BIAS;
                    mcand_d  = PW'({1'b1, fa_c});
                    mplier_d = {1'b1, fb_c};
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = MULT;
                end
            end
            MULT: begin
                if (mplier_q[0])
                    prod_d = prod_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(M - 1))
                    state_d = NORM;
            end
            NORM: begin
                if (prod_q[PW-1]) begin
                    mant_d = prod_q[PW-1 -: M];
                    g_d    = prod_q[M-1];
                    r_d    = prod_q[M-2];
                    s_d    = |prod_q[M-3:0];
                    exp_d  = exp_q + XW'(1);
                end else begin
                    mant_d = prod_q[PW-2 -: M];
                    g_d    = prod_q[M-2];
                    r_d    = prod_q[M-3];
                    s_d    = |prod_q[M-4:0];
                end
                state_d = ROUND;
            end
            ROUND: begin
                res_d   = rnd_res_c;
                state_d = DONE;
            end
            DONE: begin
                if (!OutValid) begin
                    result_d    = res_q;
                    out_valid_d = 1'b1;
                end else if (OutReady) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            mant_q   <= '0;
            g_q      <= 1'b0;
            r_q      <= 1'b0;
            s_q      <= 1'b0;
            res_q    <= '0;
            Result   <= '0;
            OutValid <= 1'b0;
            InReady  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            mant_q   <= mant_d;
            g_q      <= g_d;
            r_q      <= r_d;
            s_q      <= s_d;
            res_q    <= res_d;
            Result   <= result_d;
            OutValid <= out_valid_d;
            InReady  <= in_ready_d;
        end
    end

`ifdef FPU_MUL_FLAGS_EN
    logic [3:0] fl_q, fl_d, flags_d;

    // Exception flags: computed alongside res_q, published with Result
    always_comb begin
        fl_d    = fl_q;
        flags_d = Flags;
        case (state_q)
            UNPACK:  fl_d = {nan_c, 3'b000};
            ROUND:   fl_d = {1'b0, ovf_c, unf_c, g_q | r_q | s_q | ovf_c | unf_c};
            DONE:    if (!OutValid) flags_d = fl_q;
            default: ;
        endcase
    end

    // Flag registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fl_q  <= '0;
            Flags <= '0;
        end else begin
            fl_q  <= fl_d;
            Flags <= flags_d;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_mul_seq.sv
// tb_fpu_mul_seq: directed vector table plus hand-written handshake/reset sequences.
module tb_fpu_mul_seq;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] A, B;
    logic        InValid;
    logic        InReady;
    logic [31:0] Result;
    logic        OutValid;
    logic        OutReady;
`ifdef FPU_MUL_FLAGS_EN
    logic [3:0]  Flags;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fpu_mul_seq #(.PRECISION(32)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .A        (A),
        .B        (B),
        .InValid  (InValid),
        .InReady  (InReady),
        .Result   (Result),
        .OutValid (OutValid),
        .OutReady (OutReady)
`ifdef FPU_MUL_FLAGS_EN
        ,
        .Flags    (Flags)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation; return result, flags and edges from acceptance to OutValid
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] fl, output int lat);
        int n;
        @(negedge Clk);
        A = a; B = b; InValid = 1'b1;
        n = 0;
        while (!InReady && n < 100) begin
            @(negedge Clk);
            n++;
        end
        @(posedge Clk);
        #1;
        InValid = 1'b0; A = ~a; B = ~b;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge Clk);
            #1;
            if (OutValid) begin
                lat = i;
                break;
            end
        end
        res = Result;
`ifdef FPU_MUL_FLAGS_EN
        fl = Flags;
`else
        fl = 4'h0;
`endif
    endtask

    // Consume the result and confirm the return to IDLE
    task automatic pop(input string name);
        @(negedge Clk);
        OutReady = 1'b1;
        @(posedge Clk);
        #1;
        check({name, "_drop"}, {63'd0, OutValid}, 64'd0);
        check({name, "_idle"}, {63'd0, InReady}, 64'd1);
        OutReady = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;

        vecs[0]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 28};
        vecs[1]  = '{32'h41200000, 32'h40000000, 32'h41A00000, 4'b0000, 28};
        vecs[2]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 28};
        vecs[3]  = '{32'h00000000, 32'h7F800000, 32'h7FFFFFFF, 4'b1000, 2};
        vecs[4]  = '{32'hBF000000, 32'h00800000, 32'h80000000, 4'b0011, 28};
        vecs[5]  = '{32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF, 4'b1000, 2};
        vecs[6]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2};
        vecs[7]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 2};
        vecs[8]  = '{32'h00000001, 32'h40000000, 32'h00000000, 4'b0000, 2};
        vecs[9]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 28};
        vecs[10] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 28};
        vecs[11] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, 28};
        vecs[12] = '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4'b0001, 28};
        vecs[13] = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 28};
        vecs[14] = '{32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 4'b0000, 28};
        vecs[15] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 28};

        Reset = 1'b1; A = '0; B = '0; InValid = 1'b0; OutReady = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_inready",  {63'd0, InReady}, 64'd0);
        check("rst_outvalid", {63'd0, OutValid}, 64'd0);
        check("rst_result",   {32'd0, Result}, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("rst_release_inready", {63'd0, InReady}, 64'd1);

        for (int v = 0; v < NV; v++) begin
            run_op(vecs[v].a, vecs[v].b, res, fl, lat);
            check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].lat));
            check($sformatf("v%0d_result", v), {32'd0, res}, {32'd0, vecs[v].res});
`ifdef FPU_MUL_FLAGS_EN
            check($sformatf("v%0d_flags", v), {60'd0, fl}, {60'd0, vecs[v].fl});
`endif
            pop($sformatf("v%0d", v));
        end

        // Back-pressure: hold OutReady low for 10 cycles in DONE
        run_op(32'h3FC00000, 32'h3FC00000, res, fl, lat);
        check("stall_latency", 64'(lat), 64'd28);
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            check($sformatf("stall_hold%0d", i), {30'd0, OutValid, InReady, Result},
                  {30'd0, 1'b1, 1'b0, 32'h40100000});
        end
        pop("stall");

        // Reset in the middle of the multiply
        @(negedge Clk);
        A = 32'h41200000; B = 32'h40000000; InValid = 1'b1;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("midrst_outvalid", {63'd0, OutValid}, 64'd0);
        check("midrst_inready",  {63'd0, InReady}, 64'd0);
        check("midrst_result",   {32'd0, Result}, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("midrst_idle", {62'd0, InReady, OutValid}, {62'd0, 1'b1, 1'b0});
        run_op(32'h3FC00000, 32'h3FC00000, res, fl, lat);
        check("midrst_next_latency", 64'(lat), 64'd28);
        check("midrst_next_result", {32'd0, res}, {32'd0, 32'h40100000});
        pop("midrst_next");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
